// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver with a 2-flop input synchronizer and a single-entry
// AXI-Stream-style output buffer; framing errors and overruns pulse for one cycle.
module uart_rx_axis #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic [BITS_PER_WORD-1:0] m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     frame_err,
    output logic                     overrun
);

    localparam int CW = $clog2(CLOCKS_PER_PULSE);
    localparam int IW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(BITS_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                   state_q, state_d;
    logic                     rx_meta_q, rx_s_q;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic [BITS_PER_WORD-1:0] m_data_q, m_data_d;
    logic                     m_valid_q, m_valid_d;
    logic                     frame_err_q, overrun_q, overrun_d;
    logic                     word_good, frame_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_bad;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        word_good = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                // LSB-first on the line: shift right so bit 0 ends at the LSB
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[BITS_PER_WORD-1:1]};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        word_good = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A handshake in the same cycle as a new word frees the slot for it.
    always_comb begin
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        overrun_d = 1'b0;
        if (m_valid_q && m_ready) m_valid_d = 1'b0;
        if (word_good) begin
            if (!m_valid_q || m_ready) begin
                m_data_d  = shift_q;
                m_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis: reset, single word, back-to-back frames,
// glitch rejection, framing error/break, overrun and load-with-handshake.
module tb_uart_rx_axis;

    localparam int CPP  = 4;
    localparam int BITS = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            rx;
    logic [BITS-1:0] m_data;
    logic            m_valid;
    logic            m_ready;
    logic            frame_err;
    logic            overrun;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [BITS-1:0] xfer_q[$];
    int              xfer_cyc[$];
    int              fe_cnt = 0;
    int              ov_cnt = 0;
    int              ov_cyc = 0;

    uart_rx_axis #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD(BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer and flag recorder, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                xfer_q.push_back(m_data);
                xfer_cyc.push_back(cyc);
            end
            if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
            if (overrun === 1'b1) begin
                ov_cnt = ov_cnt + 1;
                ov_cyc = cyc;
            end
        end
    end

    task automatic clear_log();
        xfer_q.delete();
        xfer_cyc.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        ov_cyc = 0;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPP) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < BITS; i++) drive_bit(b[i]);
        drive_bit(stop_v);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            rx      = i[0];
            m_ready = ~i[0];
            @(negedge clk);
            tests_run++;
            if ({m_valid, frame_err, overrun, m_data} !== '0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got v=%b fe=%b ov=%b d=%h, want all 0",
                         i, m_valid, frame_err, overrun, m_data);
            end
        end
        rx      = 1'b1;
        m_ready = 1'b0;
        rst     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests_run++;
            if ({m_valid, frame_err, overrun, m_data} !== '0) begin
                tests_failed++;
                $display("FAIL reset_after[%0d]: got v=%b fe=%b ov=%b d=%h, want all 0",
                         i, m_valid, frame_err, overrun, m_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_word();
        int t0;
        m_ready = 1'b1;
        clear_log();
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(8);
        tests_run++;
        if (xfer_q.size() != 1) begin
            tests_failed++;
            $display("FAIL single_count: got %0d transfers, want 1", xfer_q.size());
        end else begin
            tests_run++;
            if (xfer_q[0] !== 8'hA5) begin
                tests_failed++;
                $display("FAIL single_data: got %h, want a5", xfer_q[0]);
            end
            tests_run++;
            if (xfer_cyc[0] - t0 < 40 || xfer_cyc[0] - t0 > 42) begin
                tests_failed++;
                $display("FAIL single_latency: got %0d cycles, want 40..42", xfer_cyc[0] - t0);
            end
        end
        tests_run++;
        if (fe_cnt != 0 || ov_cnt != 0) begin
            tests_failed++;
            $display("FAIL single_flags: got fe=%0d ov=%0d, want 0 0", fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [4];
        words[0] = 8'h00;
        words[1] = 8'hFF;
        words[2] = 8'h3C;
        words[3] = 8'h81;
        m_ready = 1'b1;
        clear_log();
        for (int i = 0; i < 4; i++) send_frame(words[i], 1'b1);
        idle(8);
        tests_run++;
        if (xfer_q.size() != 4) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d transfers, want 4", xfer_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (xfer_q[i] !== words[i]) begin
                    tests_failed++;
                    $display("FAIL b2b_data[%0d]: got %h, want %h", i, xfer_q[i], words[i]);
                end
            end
        end
        tests_run++;
        if (fe_cnt != 0 || ov_cnt != 0) begin
            tests_failed++;
            $display("FAIL b2b_flags: got fe=%0d ov=%0d, want 0 0", fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_glitch();
        m_ready = 1'b1;
        clear_log();
        rx = 1'b0;
        @(posedge clk);
        #1;
        idle(40);
        tests_run++;
        if (xfer_q.size() != 0 || fe_cnt != 0 || ov_cnt != 0) begin
            tests_failed++;
            $display("FAIL glitch_quiet: got xfers=%0d fe=%0d ov=%0d, want 0 0 0",
                     xfer_q.size(), fe_cnt, ov_cnt);
        end
        send_frame(8'h5A, 1'b1);
        idle(8);
        tests_run++;
        if (xfer_q.size() != 1 || xfer_q[0] !== 8'h5A) begin
            tests_failed++;
            $display("FAIL glitch_followup: got %0d transfers (first %h), want 1 of 5a",
                     xfer_q.size(), (xfer_q.size() > 0) ? xfer_q[0] : 8'hxx);
        end
    endtask

    task automatic test_frame_error();
        m_ready = 1'b1;
        clear_log();
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        idle(10);
        tests_run++;
        if (fe_cnt != 1 || xfer_q.size() != 0) begin
            tests_failed++;
            $display("FAIL ferr_break: got fe=%0d xfers=%0d, want 1 0", fe_cnt, xfer_q.size());
        end
        send_frame(8'h12, 1'b1);
        idle(8);
        tests_run++;
        if (xfer_q.size() != 1 || xfer_q[0] !== 8'h12) begin
            tests_failed++;
            $display("FAIL ferr_followup: got %0d transfers (first %h), want 1 of 12",
                     xfer_q.size(), (xfer_q.size() > 0) ? xfer_q[0] : 8'hxx);
        end
        tests_run++;
        if (fe_cnt != 1 || ov_cnt != 0) begin
            tests_failed++;
            $display("FAIL ferr_flags: got fe=%0d ov=%0d, want 1 0", fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_overrun();
        int t1;
        m_ready = 1'b0;
        clear_log();
        send_frame(8'h11, 1'b1);
        t1 = cyc;
        send_frame(8'h22, 1'b1);
        idle(8);
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL ovr_hold: got v=%b d=%h, want 1 11", m_valid, m_data);
        end
        tests_run++;
        if (ov_cnt != 1 || fe_cnt != 0) begin
            tests_failed++;
            $display("FAIL ovr_flags: got ov=%0d fe=%0d, want 1 0", ov_cnt, fe_cnt);
        end
        tests_run++;
        if (ov_cyc - t1 < 40 || ov_cyc - t1 > 43) begin
            tests_failed++;
            $display("FAIL ovr_time: got %0d cycles, want 40..43", ov_cyc - t1);
        end
        m_ready = 1'b1;
        idle(5);
        tests_run++;
        if (xfer_q.size() != 1 || xfer_q[0] !== 8'h11 || m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_drain: got xfers=%0d first=%h v=%b, want 1 11 0",
                     xfer_q.size(), (xfer_q.size() > 0) ? xfer_q[0] : 8'hxx, m_valid);
        end
    endtask

    task automatic test_load_with_handshake();
        m_ready = 1'b0;
        clear_log();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        // The cycle right after the second frame ends is the load cycle.
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        idle(6);
        tests_run++;
        if (xfer_q.size() != 1 || xfer_q[0] !== 8'h11) begin
            tests_failed++;
            $display("FAIL lh_xfer: got xfers=%0d first=%h, want 1 11",
                     xfer_q.size(), (xfer_q.size() > 0) ? xfer_q[0] : 8'hxx);
        end
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 8'h22) begin
            tests_failed++;
            $display("FAIL lh_buffer: got v=%b d=%h, want 1 22", m_valid, m_data);
        end
        tests_run++;
        if (ov_cnt != 0 || fe_cnt != 0) begin
            tests_failed++;
            $display("FAIL lh_flags: got ov=%0d fe=%0d, want 0 0", ov_cnt, fe_cnt);
        end
        m_ready = 1'b1;
        idle(4);
        tests_run++;
        if (xfer_q.size() != 2 || xfer_q[xfer_q.size()-1] !== 8'h22 || m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lh_drain: got xfers=%0d v=%b, want 2 ending in 22 and v=0",
                     xfer_q.size(), m_valid);
        end
    endtask

    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        m_ready = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_load_with_handshake();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_axis.md
Name: uart_rx_axis

Overview:
UART receiver that is the first stage of the MVM UART system. It sits on the `rx` pin, ahead of the word deserializer that assembles the K/X bus. It recovers 8N1 frames (start bit, `BITS_PER_WORD` data bits LSB-first, one stop bit) at `CLOCKS_PER_PULSE` clocks per bit. Each good word is presented on an AXI-Stream-style master port through a single-entry output buffer. Framing errors and overruns are flagged as 1-cycle pulses.

Parameters:
- `CLOCKS_PER_PULSE`, 4: clocks per UART bit. Must be >= 4; the half-bit count is `CLOCKS_PER_PULSE/2`, rounded down.
- `BITS_PER_WORD`, 8: data bits per frame.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idles high.
- `m_data`  out  `BITS_PER_WORD`  received word, LSB = first data bit on the line.
- `m_valid`  out  1  `m_data` holds an unconsumed word.
- `m_ready`  in  1  downstream accepts; the transfer happens when `m_valid && m_ready` at a rising edge.
- `frame_err`  out  1  1-cycle pulse: stop bit sampled low.
- `overrun`  out  1  1-cycle pulse: a good word was dropped because the buffer was full.

Behaviour:
- **Reset** (`rst`=1 at an edge): state=IDLE, `m_valid`=0, `m_data`=0, `frame_err`=0, `overrun`=0, both synchronizer flops=1, bit counter and clock counter=0. Reset mid-frame abandons the frame and loses any buffered word.
- **Synchronizer:** `rx` passes through a 2-flop synchronizer. Every decision below uses the synchronized value `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:** when `rx_s`=0, go to START with clock counter cleared.
- **START:** count clocks. At count `CLOCKS_PER_PULSE/2`-1 (mid start bit), sample `rx_s`:
  - 1: false start; return to IDLE with no flags.
  - 0: go to DATA with clock counter=0 and bit index=0.
- **DATA:** after every `CLOCKS_PER_PULSE` clocks (mid data bit), shift `rx_s` into the MSB of the shift register (shift right), so the first bit on the line ends up at the LSB. Increment the bit index. After the `BITS_PER_WORD`-th sample, go to STOP with clock counter=0.
- **STOP:** after `CLOCKS_PER_PULSE` clocks (mid stop bit), sample `rx_s`:
  - 1: good word; offer it to the buffer and go to IDLE in the same cycle. The next start edge is accepted from the following cycle.
  - 0: pulse `frame_err` for one cycle, discard the word, go to BREAK.
- **BREAK:** wait until `rx_s`=1, then go to IDLE. A line held low indefinitely produces exactly one `frame_err` and no spurious frames.
- **Output buffer** (one entry, evaluated on the edge after a good stop sample):
  - Buffer empty, or `m_valid && m_ready` this cycle: load `m_data`, `m_valid`=1, no overrun.
  - Buffer full and `m_ready`=0: keep the old `m_data` and `m_valid`, drop the new word, pulse `overrun` for one cycle.
  - Handshake with no load: `m_valid`→0 next cycle; `m_data` holds its last value.
- **Stability:** `m_data` and `m_valid` never change while `m_valid`=1 and `m_ready`=0, except under reset.
- **Latency:** `m_valid` rises 1 cycle after the mid-stop sample. That is about 2 (sync) + 1 + `CLOCKS_PER_PULSE/2` + (`BITS_PER_WORD`+1)·`CLOCKS_PER_PULSE` cycles after the `rx` falling edge. Benches allow ±1 cycle.
- **Throughput:** back-to-back frames with no idle time are received without loss when `m_ready`=1.
- **Output timing:** all outputs are registered; there is no combinational path from `rx` or `m_ready` to any output.

Test Plan:
- **Reset:** assert `rst` 3 cycles while toggling `rx` and `m_ready` → `m_valid`=`frame_err`=`overrun`=0 and `m_data`=0 throughout, and for 20 cycles after release with `rx`=1.
- **Single word:** `CLOCKS_PER_PULSE`=4, send 0xA5 with `m_ready`=1 → exactly one `m_valid` cycle with `m_data`=0xA5, inside the latency window; no flags.
- **Back-to-back:** send 0x00, 0xFF, 0x3C, 0x81 with zero idle between frames, `m_ready`=1 → four transfers in order with those values; no `frame_err`/`overrun`.
- **Glitch rejection:** drive `rx` low for 1 cycle, then high for 40 cycles → no `m_valid`, no flags; a following 0x5A is then received correctly.
- **Framing error and break:** send 0x55 with the stop bit=0, then hold `rx` low 30 cycles, then high, then send 0x12 → one `frame_err` pulse, no word for 0x55, then `m_data`=0x12 valid.
- **Overrun and simultaneous load/handshake:**
  - `m_ready`=0, send 0x11 then 0x22 → `m_data` stays 0x11 with `m_valid`=1, one `overrun` pulse at the 0x22 stop sample. Then raise `m_ready` → 0x11 transferred exactly once, `m_valid`→0.
  - Repeat with `m_ready` pulsed high in the exact load cycle of the second word → 0x11 transferred, `m_data`=0x22 with `m_valid` remaining 1, no `overrun`.
